ual_serial_ctrl: RTL and testbench
==================================

Name: ual_serial_ctrl

Overview:
- Bit-serial sequencer that drives one external 1-bit ALU slice (a, b, set, inva, invb, ci, selOP → f, co, sgn) over WIDTH cycles to produce a full WIDTH-bit MIPS ALU result.
- Sits between the EX-stage control and a single shared slice. It is the low-area alternative to a ripple array of WIDTH slices.
- Owns operand shift registers, the carry flip-flop, the bit counter, result assembly and the start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2); bit counter width = clog2(WIDTH).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only in IDLE
- alu_ctl  in  4  op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- a_in  in  WIDTH  operand A, captured on accepted start
- b_in  in  WIDTH  operand B, captured on accepted start
- busy  out  1  high from cycle after accept until done cycle inclusive
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  registered result, held until next accept
- zero  out  1  result == 0, registered with result
- overflow  out  1  signed overflow (ADD/SUB only, else 0)
- op_err  out  1  unsupported alu_ctl on last op
- sl_a, sl_b  out  1  current operand bits to slice
- sl_inva, sl_invb, sl_ci, sl_set  out  1  slice controls
- sl_selop  out  2  slice mux select
- sl_f, sl_co, sl_sgn  in  1  slice outputs

Behaviour:
- Reset: state=IDLE; busy, done, overflow, op_err, zero=0; result=0; all sl_* outputs 0. Reset during RUN aborts with no done.
- FSM IDLE→RUN→DONE→IDLE.
- IDLE: when start=1, latch a_in, b_in and alu_ctl; bit counter=0.
  - Supported op: carry_ff = alu_ctl[2], state=RUN.
  - Unsupported op: state=DONE, result=0, op_err=1.
  - start while busy is ignored.
- Slice controls are decoded from the latched op and held for the whole RUN:
  - sl_inva = ctl[3]; sl_invb = ctl[2].
  - sl_selop: 00 for AND/NOR, 01 for OR, 10 for ADD/SUB/SLT.
  - sl_set = 0.
- RUN cycle i (i = 0..WIDTH-1, LSB first):
  - sl_a = A[i], sl_b = B[i], sl_ci = carry_ff.
  - On the edge: carry_ff ← sl_co; sl_f shifts into the result shift register from the MSB side.
  - At i = WIDTH-1, also capture:
    - msb_sgn ← sl_sgn.
    - ovf ← sl_ci ^ sl_co, for ADD/SUB/SLT.
    - state → DONE.
- DONE (1 cycle):
  - done=1, busy=1.
  - result register loaded: shift value, or for SLT {WIDTH-1 zeros, less}.
  - zero computed from the loaded value.
  - overflow = ovf for ADD/SUB, 0 otherwise. op_err set per op.
  - Next state IDLE.
- Latency: start accepted at cycle 0 → done at cycle WIDTH+1. Back-to-back: the next start is accepted in the cycle after done (IDLE). Throughput is one op per WIDTH+2 cycles.
- start asserted in the DONE cycle is ignored. Operand changes after accept have no effect.
- Counter terminates exactly at WIDTH-1 and never wraps into a further RUN cycle.

Optional Feature:
- Macro ALU_SLT_OVF_EN.
- Defined: less = msb_sgn ^ ovf, giving a correct signed compare even when A-B overflows.
- Undefined: less = msb_sgn (classic MIPS behaviour). Wrong on overflow, e.g. A=0x7FFFFFFF, B=0x80000000 gives 1.
- The overflow output for SLT is 0 in both cases.

Test Plan:
- Bench instantiates a real 1-bit slice on the sl_* ports; all cases use WIDTH=32.
- ADD: A=0x7FFFFFFF, B=0x00000001 → done at cycle 33, result=0x80000000, overflow=1, zero=0; busy high cycles 1..33.
- SUB: A=5, B=5 → result=0, zero=1, overflow=0. NOR: A=0xF0F0F0F0, B=0x0F0F0000 → result=0x00000F0F.
- SLT: A=0xFFFFFFFF (-1), B=1 → result=1. A=0x7FFFFFFF, B=0x80000000 → result=0 with ALU_SLT_OVF_EN, 1 without.
- Illegal alu_ctl=0101 → done one cycle after accept (cycle 1 vs accept cycle 0), op_err=1, result=0. A following AND 0xFF & 0x0F → result=0x0F, op_err=0.
- start held high through an ADD; rst pulsed at RUN bit 10 → no done, busy=0, result=0. The first accept after reset completes normally. start asserted during busy/DONE is ignored, and the next op starts only from IDLE.

Source files
------------

// File: rtl/ual_serial_if.sv
// Request/response bus between EX-stage control (master) and the serial ALU sequencer (slave).
interface ual_serial_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             op_err;

  modport master (
    output start, alu_ctl, a_in, b_in,
    input  busy, done, result, zero, overflow, op_err
  );

  modport slave (
    input  start, alu_ctl, a_in, b_in,
    output busy, done, result, zero, overflow, op_err
  );
endinterface

// File: rtl/ual_serial_ctrl.sv
// Bit-serial MIPS ALU sequencer driving one external 1-bit slice, LSB first, over WIDTH cycles.
// Optional: define ALU_SLT_OVF_EN to make SLT correct when A-B overflows.
module ual_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  ual_serial_if.slave bus,
  output logic       sl_a,
  output logic       sl_b,
  output logic       sl_inva,
  output logic       sl_invb,
  output logic       sl_ci,
  output logic       sl_set,
  output logic [1:0] sl_selop,
  input  logic       sl_f,
  input  logic       sl_co,
  input  logic       sl_sgn
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       ctl_q, ctl_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, err_q, err_d;
  logic             is_arith, is_slt, last_bit, ovf_w, less;

  function automatic logic op_supported(input logic [3:0] c);
    case (c)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  // Among supported codes, bit 1 marks the adder ops (ADD/SUB/SLT); bits 1:0 = 11 is SLT only.
  assign is_arith = ctl_q[1];
  assign is_slt   = ctl_q[1] & ctl_q[0];
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign ovf_w    = carry_q ^ sl_co;

`ifdef ALU_SLT_OVF_EN
  assign less = sl_sgn ^ ovf_w;
`else
  assign less = sl_sgn;
`endif

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    ctl_d    = ctl_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    sl_a     = 1'b0;
    sl_b     = 1'b0;
    sl_inva  = 1'b0;
    sl_invb  = 1'b0;
    sl_ci    = 1'b0;
    sl_set   = 1'b0;
    sl_selop = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d   = bus.a_in;
          b_d   = bus.b_in;
          ctl_d = bus.alu_ctl;
          cnt_d = '0;
          if (op_supported(bus.alu_ctl)) begin
            carry_d = bus.alu_ctl[2];
            state_d = S_RUN;
          end else begin
            result_d = '0;
            zero_d   = 1'b1;
            ovf_d    = 1'b0;
            err_d    = 1'b1;
            state_d  = S_DONE;
          end
        end
      end

      S_RUN: begin
        sl_a     = a_q[0];
        sl_b     = b_q[0];
        sl_ci    = carry_q;
        sl_inva  = ctl_q[3];
        sl_invb  = ctl_q[2];
        sl_selop = {is_arith, ctl_q[0] & ~is_arith};
        carry_d  = sl_co;
        sh_d     = {sl_f, sh_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        if (last_bit) begin
          // The final shift value is loaded straight into result so it is valid during DONE.
          result_d = is_slt ? {{(WIDTH-1){1'b0}}, less} : sh_d;
          zero_d   = (result_d == '0);
          ovf_d    = is_arith & ~is_slt & ovf_w;
          err_d    = 1'b0;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // NOTE: datapath registers carry no reset; each is loaded on accept before it is ever observed.
  always_ff @(posedge clk) begin
    a_q     <= a_d;
    b_q     <= b_d;
    sh_q    <= sh_d;
    ctl_q   <= ctl_d;
    cnt_q   <= cnt_d;
    carry_q <= carry_d;
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
  assign bus.op_err   = err_q;
endmodule

// File: tb/tb_ual_serial_ctrl.sv
// Self-checking bench for ual_serial_ctrl with a behavioural 1-bit slice and an arithmetic reference model.
module tb_ual_serial_ctrl;
  localparam int WIDTH = 32;

  localparam logic [3:0] C_AND = 4'b0000, C_OR  = 4'b0001, C_ADD = 4'b0010,
                         C_SUB = 4'b0110, C_SLT = 4'b0111, C_NOR = 4'b1100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sl_a, sl_b, sl_inva, sl_invb, sl_ci, sl_set;
  logic [1:0] sl_selop;
  logic       sl_f, sl_co, sl_sgn;

  int checks = 0;
  int errors = 0;

  ual_serial_if #(.WIDTH(WIDTH)) bus ();

  ual_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sl_a     (sl_a),
    .sl_b     (sl_b),
    .sl_inva  (sl_inva),
    .sl_invb  (sl_invb),
    .sl_ci    (sl_ci),
    .sl_set   (sl_set),
    .sl_selop (sl_selop),
    .sl_f     (sl_f),
    .sl_co    (sl_co),
    .sl_sgn   (sl_sgn)
  );

  always #5 clk = ~clk;

  // Behavioural 1-bit MIPS ALU slice.
  logic ae, be, sum;
  always_comb begin
    ae     = sl_a ^ sl_inva;
    be     = sl_b ^ sl_invb;
    sum    = ae ^ be ^ sl_ci;
    sl_co  = (ae & be) | (ae & sl_ci) | (be & sl_ci);
    sl_sgn = sum;
    case (sl_selop)
      2'b00:   sl_f = ae & be;
      2'b01:   sl_f = ae | be;
      2'b10:   sl_f = sum;
      default: sl_f = sl_set;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-word arithmetic from the op definitions.
  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        err;
  } exp_t;

  function automatic exp_t calc(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    exp_t        e;
    logic [31:0] d;
    e = '0;
    case (c)
      C_AND: e.res = a & b;
      C_OR:  e.res = a | b;
      C_NOR: e.res = ~(a | b);
      C_ADD: begin
        e.res = a + b;
        e.ovf = (a[31] == b[31]) && (e.res[31] != a[31]);
      end
      C_SUB: begin
        e.res = a - b;
        e.ovf = (a[31] != b[31]) && (e.res[31] != a[31]);
      end
      C_SLT: begin
        d = a - b;
`ifdef ALU_SLT_OVF_EN
        e.res = {31'd0, ($signed(a) < $signed(b))};
`else
        e.res = {31'd0, d[31]};
`endif
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // m_left: cycles remaining until the model returns to idle; 1 means the done cycle.
  int          m_left = 0;
  exp_t        pend   = '0;
  logic [31:0] m_res  = '0;
  logic        m_zero = 1'b0, m_ovf = 1'b0, m_err = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_res  <= '0;
      m_zero <= 1'b0;
      m_ovf  <= 1'b0;
      m_err  <= 1'b0;
    end else if (m_left == 0) begin
      if (bus.start) begin
        pend <= calc(bus.a_in, bus.b_in, bus.alu_ctl);
        if (calc(bus.a_in, bus.b_in, bus.alu_ctl).err) begin
          m_left <= 1;
          m_res  <= '0;
          m_zero <= 1'b1;
          m_ovf  <= 1'b0;
          m_err  <= 1'b1;
        end else begin
          m_left <= WIDTH + 1;
        end
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_res  <= pend.res;
        m_zero <= (pend.res == '0);
        m_ovf  <= pend.ovf;
        m_err  <= pend.err;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("busy", 32'(bus.busy), 32'(m_left > 0));
    check("done", 32'(bus.done), 32'(m_left == 1));
    check("result", bus.result, m_res);
    check("zero", 32'(bus.zero), 32'(m_zero));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("op_err", 32'(bus.op_err), 32'(m_err));
    if (m_left <= 1)
      check("slice_idle", {24'd0, sl_a, sl_b, sl_inva, sl_invb, sl_ci, sl_set, sl_selop}, 32'd0);
  end

  task automatic wait_done(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < max);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic [31:0] exp_res, input logic exp_zero,
                        input logic exp_ovf, input logic exp_err, input int exp_lat);
    int n;
    #1;
    bus.a_in    = a;
    bus.b_in    = b;
    bus.alu_ctl = c;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a_in  = ~a;
    bus.b_in  = ~b;
    wait_done(40, n);
    check({name, "_latency"}, n, exp_lat);
    check({name, "_result"}, bus.result, exp_res);
    check({name, "_zero"}, 32'(bus.zero), 32'(exp_zero));
    check({name, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
    check({name, "_err"}, 32'(bus.op_err), 32'(exp_err));
    check({name, "_busy_at_done"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int n;
    bus.start   = 1'b0;
    bus.alu_ctl = '0;
    bus.a_in    = '0;
    bus.b_in    = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", {28'd0, bus.done, bus.zero, bus.overflow, bus.op_err}, 32'd0);
    check("rst_slice", {24'd0, sl_a, sl_b, sl_inva, sl_invb, sl_ci, sl_set, sl_selop}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);

    run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, C_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 33);
    run_op("sub_eq",  32'd5, 32'd5, C_SUB, 32'd0, 1'b1, 1'b0, 1'b0, 33);
    run_op("nor",     32'hF0F0_F0F0, 32'h0F0F_0000, C_NOR, 32'h0000_0F0F, 1'b0, 1'b0, 1'b0, 33);
    run_op("slt_neg", 32'hFFFF_FFFF, 32'h0000_0001, C_SLT, 32'd1, 1'b0, 1'b0, 1'b0, 33);
`ifdef ALU_SLT_OVF_EN
    run_op("slt_ovf", 32'h7FFF_FFFF, 32'h8000_0000, C_SLT, 32'd0, 1'b1, 1'b0, 1'b0, 33);
`else
    run_op("slt_ovf", 32'h7FFF_FFFF, 32'h8000_0000, C_SLT, 32'd1, 1'b0, 1'b0, 1'b0, 33);
`endif
    run_op("illegal", 32'h1234_5678, 32'h9ABC_DEF0, 4'b0101, 32'd0, 1'b1, 1'b0, 1'b1, 1);
    run_op("and",     32'h0000_00FF, 32'h0000_000F, C_AND, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 33);
    run_op("or",      32'h1234_0000, 32'h0000_5678, C_OR, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 33);
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, C_SUB, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 33);

    // Abort: start held high, reset pulsed during RUN bit 10.
    #1;
    bus.a_in    = 32'h1234_5678;
    bus.b_in    = 32'h1111_1111;
    bus.alu_ctl = C_ADD;
    bus.start   = 1'b1;
    @(posedge clk);
    repeat (11) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", bus.result, 32'd0);
    #1 rst = 1'b0;

    // First accept after reset; operands change after accept and must not matter.
    @(posedge clk);
    #1;
    bus.a_in = 32'hDEAD_0000;
    bus.b_in = 32'h0000_BEEF;
    wait_done(40, n);
    check("post_rst_latency", n, 33);
    check("post_rst_result", bus.result, 32'h2345_6789);

    // start still high through DONE: the next op is accepted only from IDLE.
    wait_done(40, n);
    check("held_start_spacing", n, 34);
    check("held_start_result", bus.result, 32'hDEAD_BEEF);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("final_idle", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
